modulador_psk: RTL and testbench
================================

# modulador_psk

Parametrised BPSK baseband modulator that replaces the fixed 8-bit, 32-sample modulator. It accepts bytes over a valid/ready handshake and serialises them LSB first. Each bit is emitted as one full sine period of 2**SPS_LOG2 offset-binary samples: bit 0 at phase 0°, bit 1 at phase 180°. The `saida` bus drives the DAC directly; the byte source is the framing/UART front end.

## Interface
- SAMPLE_W, 8: DAC sample width, offset-binary.
- SPS_LOG2, 5: log2 of samples per bit; N = 2**SPS_LOG2, N ≥ 4.
- BYTE_W, 8: bits per input word.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- dado  in  BYTE_W  word to transmit.
- dado_valid  in  1  `dado` holds a word.
- dado_ready  out  1  block accepts `dado` this cycle. Combinational.
- saida  out  SAMPLE_W  registered DAC sample.
- busy  out  1  registered; high while in SEND.
- flag_byte  out  1  registered; one-cycle pulse when the last sample of a word has been registered into `saida`.

## Operation
- Constants:
  - MID = 2**(SAMPLE_W-1).
  - AMP = MID-1.
  - LUT[k] = MID + round(AMP·sin(2πk/N)), for k = 0..N-1.
- States:
  - IDLE → SEND on accept.
  - SEND → SEND on back-to-back accept.
  - SEND → IDLE after the last sample of the last bit when no accept occurs.
- Accept: `dado_valid && dado_ready`.
- `dado_ready` = (state==IDLE) || (state==SEND && smp_cnt==N-1 && bit_cnt==BYTE_W-1).
- On accept:
  - Shift register ← `dado`.
  - smp_cnt ← 0, bit_cnt ← 0.
  - State ← SEND.
- Each SEND cycle:
  - saida ← LUT[(smp_cnt + (tx_bit ? N/2 : 0)) mod N]. The index sum is SPS_LOG2 bits wide and wraps naturally.
  - smp_cnt increments. At N-1 it wraps to 0, the shift register shifts right, and bit_cnt increments.
- tx_bit:
  - Without the macro, tx_bit = shift register LSB.
  - With the macro, see Configuration.
- IDLE: saida ← MID every cycle. The output therefore never glitches, because LUT[0] = LUT[N/2] = MID.
- `flag_byte` pulses in the cycle after the sample smp_cnt==N-1, bit_cnt==BYTE_W-1 is registered. It also pulses on back-to-back words.
- `dado` and `dado_valid` are ignored whenever `dado_ready` is low. The word is latched at accept and later changes to `dado` have no effect.
- Reset values:
  - saida = MID, busy = 0, flag_byte = 0.
  - State IDLE, counters 0, shift register 0, phase reference 0.
- Reset mid-word: the word is abandoned and `flag_byte` does not pulse. Reset takes priority over a simultaneous accept.

## Timing
- Accept at edge E → the first sample, LUT[0 or N/2], is registered at E+1.
- One word occupies exactly BYTE_W·N cycles of `saida`.
- Back-to-back: continuous stream with no MID gap between words; sample 0 of word 2 lands one cycle after the last sample of word 1.
- Throughput: one word per BYTE_W·N cycles.
- `busy` falls in the cycle after the final sample when no new word is accepted. In that same cycle `saida` returns to MID.

## Configuration
- MODULADOR_DIFF_EN
  - Defined: differential BPSK. tx_bit = phase_ref XOR data_bit. phase_ref ← tx_bit at every bit boundary.
  - phase_ref persists across words and IDLE periods; only `rst` clears it.
  - Undefined: absolute BPSK with tx_bit = data_bit, and no phase_ref register.

## Structure
- Package `modulador_pkg`:
  - State enum (IDLE, SEND).
  - `function automatic` computing LUT entries from SAMPLE_W and SPS_LOG2 at elaboration; `$sin` in a constant function, rounded half away from zero.
  - MID helper.
- Sub-module `modulador_sine_lut`:
  - Parameters SAMPLE_W and SPS_LOG2.
  - Combinational index-to-sample ROM, built at elaboration.
  - The top registers its output into `saida`.

## Test plan
Default parameters (8, 5, 8), so N = 32 and MID = 128.
- Reset → saida=128, dado_ready=1, busy=0, flag_byte=0, held for 10 cycles with dado_valid=0.
- Send 0x00 → 256 samples with busy high. Per bit: k=0 → 128, k=4 → 218, k=8 → 255, k=16 → 128, k=24 → 1. flag_byte pulses once, then saida=128.
- Send 0x01 → bit 0 inverted (k=8 → 1, k=24 → 255). Bits 1–7 are phase 0 (k=8 → 255).
- 0xA5 then 0x3C with dado_valid held → 512 contiguous samples. dado_ready is high only at the final sample of word 1. No 128 inserted at k≠0/16, and flag_byte pulses twice.
- rst asserted at sample 100 of 0xFF → next cycle saida=128 and busy=0. No flag_byte pulse. The next word starts cleanly at sample 0.
- MODULADOR_DIFF_EN defined, send 0xFF then 0xFF → tx_bit alternates 1,0,1,0… across all 16 bits, so the k=8 sample alternates 1,255,…. Phase continuity holds across the word boundary.

Source files
------------

// File: rtl/modulador_pkg.sv
// Shared types and elaboration-time helpers for the BPSK modulator.
package modulador_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Offset-binary mid-scale code: 2**(sample_w-1).
  function automatic int mid_value(input int sample_w);
    return 1 << (sample_w - 1);
  endfunction

  // One sine-table entry, rounded half away from zero.
  function automatic int lut_entry(input int sample_w, input int sps_log2, input int k);
    real pi;
    real v;
    int  amp;
    int  n;
    int  r;
    pi  = 3.14159265358979323846;
    n   = 1 << sps_log2;
    amp = mid_value(sample_w) - 1;
    v   = real'(amp) * $sin(2.0 * pi * real'(k) / real'(n));
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(-v + 0.5);
    return mid_value(sample_w) + r;
  endfunction

endpackage

// File: rtl/modulador_sine_lut.sv
// Combinational sine ROM: one full period of 2**SPS_LOG2 offset-binary samples.
module modulador_sine_lut
  import modulador_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int SPS_LOG2 = 5
) (
  input  logic [SPS_LOG2-1:0] idx_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  localparam int N = 1 << SPS_LOG2;

  logic [SAMPLE_W-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam int VAL = lut_entry(SAMPLE_W, SPS_LOG2, k);
    assign rom[k] = SAMPLE_W'(VAL);
  end

  assign sample_o = rom[idx_i];

endmodule

// File: rtl/modulador_psk.sv
// BPSK baseband modulator: bytes in (LSB first), one sine period per bit out.
// Define MODULADOR_DIFF_EN for differential encoding against a persistent phase reference.
module modulador_psk
  import modulador_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int SPS_LOG2 = 5,
  parameter int BYTE_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   dado,
  input  logic                dado_valid,
  output logic                dado_ready,
  output logic [SAMPLE_W-1:0] saida,
  output logic                busy,
  output logic                flag_byte
);

  localparam int                  BIT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [SAMPLE_W-1:0] MID   = SAMPLE_W'(mid_value(SAMPLE_W));
  localparam logic [SPS_LOG2-1:0] HALF  = {1'b1, {(SPS_LOG2-1){1'b0}}};
  localparam logic [SPS_LOG2-1:0] SMP_MAX = '1;
  localparam logic [BIT_W-1:0]    BIT_MAX = BIT_W'(BYTE_W - 1);

  state_e              state_q;
  logic [SPS_LOG2-1:0] smp_cnt_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [BYTE_W-1:0]   shift_q;
  logic [SAMPLE_W-1:0] saida_q;
  logic                busy_q;
  logic                flag_byte_q;

  logic                smp_last;
  logic                word_last;
  logic                accept;
  logic                tx_bit;
  logic [SPS_LOG2-1:0] lut_idx;
  logic [SAMPLE_W-1:0] lut_sample;

  // Handshake: a word is taken on any edge where dado_valid && dado_ready.
  // dado_ready is high in IDLE and on the final sample of a word, so words
  // can chain without a gap; dado is ignored whenever dado_ready is low.
  assign smp_last   = (smp_cnt_q == SMP_MAX);
  assign word_last  = (state_q == ST_SEND) && smp_last && (bit_cnt_q == BIT_MAX);
  assign dado_ready = (state_q == ST_IDLE) || word_last;
  assign accept     = dado_valid && dado_ready;

`ifdef MODULADOR_DIFF_EN
  logic phase_ref_q;
  assign tx_bit = phase_ref_q ^ shift_q[0];

  // The reference survives word boundaries and IDLE; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_ref_q <= 1'b0;
    end else if ((state_q == ST_SEND) && smp_last) begin
      phase_ref_q <= tx_bit;
    end
  end
`else
  assign tx_bit = shift_q[0];
`endif

  // A half-table offset gives the 180 degree phase; the sum wraps mod N.
  assign lut_idx = smp_cnt_q + (tx_bit ? HALF : '0);

  modulador_sine_lut #(
    .SAMPLE_W (SAMPLE_W),
    .SPS_LOG2 (SPS_LOG2)
  ) u_lut (
    .idx_i    (lut_idx),
    .sample_o (lut_sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      smp_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      saida_q     <= MID;
      busy_q      <= 1'b0;
      flag_byte_q <= 1'b0;
    end else begin
      flag_byte_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          saida_q <= MID;
          busy_q  <= 1'b0;
          if (accept) begin
            shift_q   <= dado;
            smp_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= ST_SEND;
          end
        end
        ST_SEND: begin
          saida_q   <= lut_sample;
          busy_q    <= 1'b1;
          smp_cnt_q <= smp_cnt_q + SPS_LOG2'(1);
          if (smp_last) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
          // busy drops one edge later, together with saida returning to MID.
          if (word_last) begin
            flag_byte_q <= 1'b1;
            bit_cnt_q   <= '0;
            if (accept) begin
              shift_q   <= dado;
              smp_cnt_q <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign saida     = saida_q;
  assign busy      = busy_q;
  assign flag_byte = flag_byte_q;

endmodule

// File: tb/tb_modulador_psk.sv
// Bench for modulador_psk: directed word sequences with randomized filler on dado/dado_valid.
module tb_modulador_psk;

  localparam int SAMPLE_W = 8;
  localparam int SPS_LOG2 = 5;
  localparam int BYTE_W   = 8;
  localparam int N        = 1 << SPS_LOG2;
  localparam int MID      = 1 << (SAMPLE_W - 1);
  localparam int AMP      = MID - 1;
  localparam int WS       = BYTE_W * N;
  localparam real PI      = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                rst;
  logic [BYTE_W-1:0]   dado;
  logic                dado_valid;
  logic                dado_ready;
  logic [SAMPLE_W-1:0] saida;
  logic                busy;
  logic                flag_byte;

  int n_checks = 0;
  int n_fail   = 0;
  int ref_phase = 0;
  logic [SAMPLE_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  modulador_psk #(
    .SAMPLE_W (SAMPLE_W),
    .SPS_LOG2 (SPS_LOG2),
    .BYTE_W   (BYTE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dado       (dado),
    .dado_valid (dado_valid),
    .dado_ready (dado_ready),
    .saida      (saida),
    .busy       (busy),
    .flag_byte  (flag_byte)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: amplitude-scaled sine with a pi phase shift for a transmitted 1.
  function automatic int model_sample(input int tx, input int k);
    real ang;
    real v;
    int  r;
    ang = 2.0 * PI * real'(k) / real'(N) + ((tx != 0) ? PI : 0.0);
    v   = real'(AMP) * $sin(ang);
    if (v >= 0.0) r = int'($floor(v + 0.5));
    else          r = -int'($floor(-v + 0.5));
    return MID + r;
  endfunction

  // scoreboard fill: expected samples of one word
  task automatic load_word(input logic [BYTE_W-1:0] w);
    int data;
    int tx;
    for (int b = 0; b < BYTE_W; b++) begin
      data = int'(w[b]);
`ifdef MODULADOR_DIFF_EN
      tx = ref_phase ^ data;
      ref_phase = tx;
`else
      tx = data;
`endif
      for (int k = 0; k < N; k++) exp_q.push_back(SAMPLE_W'(model_sample(tx, k)));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_saida"}, saida, MID);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_flag"}, flag_byte, 0);
    check({tag, "_ready"}, dado_ready, 1);
  endtask

  // driver: sends the words back to back; abort_at >= 0 asserts rst before that sample
  task automatic stream(input logic [BYTE_W-1:0] words[$], input int abort_at);
    int nw;
    int total;
    int widx;
    nw = words.size();
    total = nw * WS;
    foreach (words[j]) load_word(words[j]);
    @(negedge clk);
    dado = words[0];
    dado_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("accept_gap_saida", saida, MID);
    check("accept_gap_busy", busy, 0);
    dado = BYTE_W'($urandom);
    dado_valid = 1'($urandom_range(0, 1));
    for (int i = 0; i < total; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        dado_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_saida", saida, MID);
        check("abort_busy", busy, 0);
        check("abort_flag", flag_byte, 0);
        rst = 1'b0;
        dado_valid = 1'b0;
        ref_phase = 0;
        exp_q.delete();
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 1, 0);
      end else begin
        check("saida", saida, exp_q.pop_front());
      end
      check("busy", busy, 1);
      check("flag_byte", flag_byte, ((i % WS) == WS - 1) ? 1 : 0);
      check("dado_ready", dado_ready, (((i % WS) == WS - 2) || (i == total - 1)) ? 1 : 0);
      widx = i / WS;
      if ((i % WS) == WS - 2 && widx + 1 < nw) begin
        dado = words[widx + 1];
        dado_valid = 1'b1;
      end else begin
        dado = BYTE_W'($urandom);
        dado_valid = ((i % WS) == WS - 2 || i >= total - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_idle("post_word");
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  logic [BYTE_W-1:0] wq[$];

  initial begin
    rst = 1'b1;
    dado = '0;
    dado_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_phase = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("reset_hold");
    end

    wq = '{8'h00};       stream(wq, -1);
    wq = '{8'h01};       stream(wq, -1);
    wq = '{8'hA5, 8'h3C}; stream(wq, -1);
    wq = '{8'hFF};       stream(wq, 100);
    wq = '{8'hFF};       stream(wq, -1);

    // reset beats a simultaneous accept in IDLE
    @(negedge clk);
    rst = 1'b1;
    dado = 8'hFF;
    dado_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dado_valid = 1'b0;
    ref_phase = 0;
    check("rst_prio_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    check_idle("rst_prio");

    wq = '{BYTE_W'($urandom), BYTE_W'($urandom), BYTE_W'($urandom)};
    stream(wq, -1);
    wq = '{8'hFF, 8'hFF}; stream(wq, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
